// File: rtl/approx_add_rr_sched_if.sv
// Request/response bundle for the shared approximate adder.
// The master modport is the requester/sink side; the slave modport is the scheduler.
interface approx_add_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_exact;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_exact;

  modport master (
    output req_valid, req_a, req_b, req_exact, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_exact
  );

  modport slave (
    input  req_valid, req_a, req_b, req_exact, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_exact
  );
endinterface

// File: rtl/approx_add_rr_sched.sv
// Round-robin scheduler sharing one approximate/exact ripple adder across N_REQ requesters.
// Define APPROX_ERR_STATS_EN to add err_sum/err_cnt error statistics with err_clr.
module approx_add_rr_sched #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  approx_add_rr_sched_if.slave       bus
`ifdef APPROX_ERR_STATS_EN
  ,
  input  logic                       err_clr,
  output logic [31:0]                err_sum,
  output logic [31:0]                err_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [WIDTH:0] LOW_MASK = {(WIDTH+1){1'b1}} >> (WIDTH + 1 - APPROX_BITS);

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_valid;
  logic [WIDTH:0]   r_data;
  logic [ID_W-1:0]  r_id;
  logic             r_exact;

  logic             w_free;
  logic             w_found;
  logic             w_push;
  logic [ID_W-1:0]  w_grant_idx;
  logic [ID_W-1:0]  w_next_ptr;
  logic [N_REQ-1:0] w_grant;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_exact;
  logic [WIDTH-1:0] w_a_hi;
  logic [WIDTH-1:0] w_b_hi;
  logic [WIDTH:0]   w_exact_sum;
  logic [WIDTH:0]   w_approx_sum;
  logic [WIDTH:0]   w_result;

  // Descending scan: the last hit written is the one closest to r_rr_ptr.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_found     = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = ID_W'(idx);
      end
    end
  end

  assign w_free        = ~r_valid | bus.rsp_ready;
  assign w_push        = w_found & w_free & ~rst;
  assign w_grant       = w_push ? (N_REQ'(1) << w_grant_idx) : '0;
  assign bus.req_ready = w_grant;
  assign w_next_ptr    = (int'(w_grant_idx) == N_REQ - 1) ? '0 : w_grant_idx + 1'b1;

  assign w_sel_a     = bus.req_a[w_grant_idx*WIDTH +: WIDTH];
  assign w_sel_b     = bus.req_b[w_grant_idx*WIDTH +: WIDTH];
  assign w_sel_exact = bus.req_exact[w_grant_idx];

  // Approximate cells drive constant ones; the upper chain starts with carry-in 0.
  assign w_a_hi       = w_sel_a >> APPROX_BITS;
  assign w_b_hi       = w_sel_b >> APPROX_BITS;
  assign w_exact_sum  = {1'b0, w_sel_a} + {1'b0, w_sel_b};
  assign w_approx_sum = (({1'b0, w_a_hi} + {1'b0, w_b_hi}) << APPROX_BITS) | LOW_MASK;
  assign w_result     = w_sel_exact ? w_exact_sum : w_approx_sum;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_id     <= '0;
      r_exact  <= 1'b0;
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_valid  <= 1'b1;
      r_data   <= w_result;
      r_id     <= w_grant_idx;
      r_exact  <= w_sel_exact;
      r_rr_ptr <= w_next_ptr;
    end else if (bus.rsp_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_exact = r_exact;

`ifdef APPROX_ERR_STATS_EN
  logic [31:0]    r_err_sum;
  logic [31:0]    r_err_cnt;
  logic [WIDTH:0] w_err;
  logic [32:0]    w_err_sum_next;

  assign w_err = (w_exact_sum > w_approx_sum) ? (w_exact_sum - w_approx_sum)
                                              : (w_approx_sum - w_exact_sum);
  assign w_err_sum_next = {1'b0, r_err_sum} + 33'(w_err);

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_err_sum <= '0;
      r_err_cnt <= '0;
    end else if (w_push && !w_sel_exact) begin
      r_err_sum <= w_err_sum_next[32] ? 32'hFFFF_FFFF : w_err_sum_next[31:0];
      if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign err_sum = r_err_sum;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_approx_add_rr_sched.sv
// Directed bench for approx_add_rr_sched: vector table plus arbitration, backpressure,
// reset and (with APPROX_ERR_STATS_EN) error-statistics sequences.
module tb_approx_add_rr_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        ex;
    logic [16:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs [9];

  approx_add_rr_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

`ifdef APPROX_ERR_STATS_EN
  logic        err_clr;
  logic [31:0] err_sum;
  logic [31:0] err_cnt;
`endif

  approx_add_rr_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .APPROX_BITS(11)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef APPROX_ERR_STATS_EN
    ,
    .err_clr (err_clr),
    .err_sum (err_sum),
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic ex);
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
    bus.req_exact[id]            = ex;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{0, 16'h0800, 16'h0800, 1'b0, 17'h017FF};
    vecs[1] = '{1, 16'h0800, 16'h0800, 1'b1, 17'h01000};
    vecs[2] = '{2, 16'hFFFF, 16'h0001, 1'b1, 17'h10000};
    vecs[3] = '{3, 16'hFFFF, 16'h0001, 1'b0, 17'h0FFFF};
    vecs[4] = '{0, 16'h1234, 16'h5678, 1'b1, 17'h068AC};
    vecs[5] = '{1, 16'h1234, 16'h5678, 1'b0, 17'h067FF};
    vecs[6] = '{2, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE};
    vecs[7] = '{3, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1F7FF};
    vecs[8] = '{0, 16'h0000, 16'h0000, 1'b0, 17'h007FF};

`ifdef APPROX_ERR_STATS_EN
    err_clr = 1'b0;
`endif
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_exact = '0;
    bus.rsp_ready = 1'b0;

    // Reset: no grants while rst is high, outputs cleared.
    step();
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    step();
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_data",  32'(bus.rsp_data),  32'h0);
    check("reset_rsp_id",    32'(bus.rsp_id),    32'h0);
    check("reset_rsp_exact", 32'(bus.rsp_exact), 32'h0);
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step();

    // Vector table: one requester at a time, results returned one cycle later.
    for (int i = 0; i < 9; i++) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ex);
      bus.req_valid = 4'(1 << vecs[i].id);
      #1;
      check($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'(1 << vecs[i].id));
      step();
      check($sformatf("vec%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("vec%0d_rsp_data", i),  32'(bus.rsp_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d_rsp_id", i),    32'(bus.rsp_id),    32'(vecs[i].id));
      check($sformatf("vec%0d_rsp_exact", i), 32'(bus.rsp_exact), 32'(vecs[i].ex));
    end

    // Pop without push empties the slot.
    bus.req_valid = '0;
    step();
    check("pop_only_rsp_valid", 32'(bus.rsp_valid), 32'h0);

    // Round-robin from pointer 0 with all requesters valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 16'(i * 16'h0100 + 1), 16'h0010, 1'b1);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr%0d_req_ready", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
      check($sformatf("rr%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("rr%0d_rsp_id", k),    32'(bus.rsp_id),    32'(k % 4));
      check($sformatf("rr%0d_rsp_data", k),  32'(bus.rsp_data),  32'((k % 4) * 256 + 17));
    end

    // Backpressure: slot holds requester 0's result, nothing granted.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), 32'h0);
      step();
      check($sformatf("bp%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("bp%0d_rsp_id", k),    32'(bus.rsp_id),    32'h0);
      check($sformatf("bp%0d_rsp_data", k),  32'(bus.rsp_data),  32'h011);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", 32'(bus.req_ready), 32'h2);
    step();
    check("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("bp_release_rsp_id",    32'(bus.rsp_id),    32'h1);
    check("bp_release_rsp_data",  32'(bus.rsp_data),  32'h111);

    // Reset mid-stream with pointer at 2: result dropped, pointer back to 0.
    bus.req_valid = 4'b0101;
    rst           = 1'b1;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst = 1'b0;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    #1;
    check("postrst_req_ready", 32'(bus.req_ready), 32'h1);
    step();
    check("postrst_rsp_id",   32'(bus.rsp_id),   32'h0);
    check("postrst_rsp_data", 32'(bus.rsp_data), 32'h011);
    bus.req_valid = '0;
    step();

`ifdef APPROX_ERR_STATS_EN
    // Error statistics: two approx 0x800+0x800 adds each contribute 2047.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("stats_clr_sum", err_sum, 32'd0);
    check("stats_clr_cnt", err_cnt, 32'd0);
    set_req(0, 16'h0800, 16'h0800, 1'b0);
    bus.req_valid = 4'h1;
    step();
    step();
    check("stats_two_sum", err_sum, 32'd4094);
    check("stats_two_cnt", err_cnt, 32'd2);
    set_req(0, 16'h0800, 16'h0800, 1'b1);
    step();
    check("stats_exact_sum", err_sum, 32'd4094);
    check("stats_exact_cnt", err_cnt, 32'd2);
    set_req(0, 16'h0800, 16'h0800, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr       = 1'b0;
    bus.req_valid = '0;
    check("stats_clr_prio_sum", err_sum, 32'd0);
    check("stats_clr_prio_cnt", err_cnt, 32'd0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_add_rr_sched.md
Name: approx_add_rr_sched

Overview:
- Shares one 16-bit approximate ripple-carry adder datapath between N_REQ requesters, using round-robin arbitration and valid/ready handshakes.
- Each request selects approximate mode or exact mode.
- One registered result slot with backpressure; sits between workload generators (MSE/area characterisation benches, accelerator lanes) and the result sink.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width
- APPROX_BITS, 11, number of LSB cells implemented as constant-output approximate cells (0..WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request valid per requester
- req_ready  out  N_REQ  grant/accept per requester, one-hot or zero
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- req_exact  in  N_REQ  1 = exact add, 0 = approximate add
- rsp_valid  out  1  result slot occupied
- rsp_ready  in  1  sink accepts result
- rsp_data  out  WIDTH+1  sum
- rsp_id  out  clog2(N_REQ)  index of the requester that owns rsp_data
- rsp_exact  out  1  mode of the returned result

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_exact=0, rr_ptr=0 (requester 0 highest priority). req_ready is combinational, so it is 0 while rsp_valid=1 and rsp_ready=0.
- Slot free: free = ~rsp_valid | rsp_ready.
- Grant:
  - Combinational and one-hot.
  - Goes to the first requester with req_valid=1, searching upward from rr_ptr with wrap-around.
  - Asserted only when free=1.
  - req_ready[i] = grant[i].
  - Transfer occurs when req_valid[i] & req_ready[i].
- On transfer in cycle t:
  - rsp_data/rsp_id/rsp_exact load at the edge ending t.
  - rsp_valid=1 in cycle t+1. Latency is exactly 1 cycle.
  - rr_ptr <= (granted index + 1) mod N_REQ.
- Simultaneous pop and push (rsp_valid & rsp_ready & new grant): the slot is overwritten with the new result and rsp_valid stays 1. This gives full throughput, 1 result/cycle.
- Pop without push: rsp_valid <= 0. rsp_data keeps its last value (don't-care to the sink).
- No request pending and slot free: rr_ptr unchanged.
- Output stability: while rsp_valid=1 and rsp_ready=0, rsp_* must not change.
- Exact arithmetic: rsp_data = a + b (WIDTH+1 bits, full carry-out).
- Approximate arithmetic:
  - rsp_data[APPROX_BITS-1:0] = all ones.
  - rsp_data[WIDTH:APPROX_BITS] = a[WIDTH-1:APPROX_BITS] + b[WIDTH-1:APPROX_BITS], with carry-in 0.
  - APPROX_BITS=0 is identical to exact mode.
  - APPROX_BITS=WIDTH gives all-ones low bits and rsp_data[WIDTH]=0.
- Reset mid-operation: a pending result is discarded, the pointer returns to 0, and no grant is issued in the reset cycle.
- Requesters must hold req_a/req_b/req_exact stable while req_valid=1 and not granted. A requester may drop req_valid before it is granted; no state is affected.

Optional Feature:
- Macro: APPROX_ERR_STATS_EN.
- When defined, adds the following outputs:
  - err_sum (32b): saturating sum of |exact_sum − approx_sum| over all accepted approximate-mode transactions.
  - err_cnt (32b): count of those transactions, saturating.
  - err_clr (input, 1b): synchronously zeroes both counters. It has priority over a same-cycle increment.
- Counters update at the transfer edge and reset to 0.
- When not defined: these ports and counters are absent, and the datapath and timing are unchanged.

Test Plan:
- Approx single request: req 0, a=0x0800, b=0x0800, exact=0 → next cycle rsp_valid=1, rsp_data=0x017FF, rsp_id=0. The same operands with exact=1 → 0x01000.
- Carry boundary: a=0xFFFF, b=0x0001 → exact 0x10000; approx 0x0FFFF (rsp_data[16]=0).
- Round-robin: all 4 req_valid held high, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles, one result per cycle, rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 3 cycles with a result held → req_ready all 0 and rsp_* stable. Raising rsp_ready gives a pop and a new grant in the same cycle.
- Reset mid-stream: assert rst while rsp_valid=1 and rr_ptr=2 → next cycle rsp_valid=0. The first grant after reset goes to requester 0 when requesters 0 and 2 are both valid.
- APPROX_ERR_STATS_EN: two approx transactions 0x0800+0x0800 → err_sum=4094, err_cnt=2. An exact transaction leaves both unchanged. err_clr → both 0.
